// File: rtl/game_score_fsm.sv
// Game state and score keeper feeding the VGA score display.
// Debounces start_btn and tracks score, lives and the frame-based round timer.
module game_score_fsm #(
  parameter int MAX_SCORE       = 12,
  parameter int LIVES           = 3,
  parameter int TIMEOUT_FRAMES  = 1800,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        hit,
  input  logic        miss,
  input  logic        screenEnd,
  output logic        ingame,
  output logic [31:0] score,
  output logic [1:0]  lives_left,
  output logic [11:0] frames_left,
  output logic        game_won
);

  localparam int SW = $clog2(MAX_SCORE + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_e;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;

  state_e        state_q, state_d;
  logic          ingame_q, ingame_d;
  logic [SW-1:0] score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [11:0]   frames_q, frames_d;
  logic          won_q, won_d;
  logic          win;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    start_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  // A winning hit masks miss and timeout in the same cycle.
  assign win = hit && (score_q >= SW'(MAX_SCORE - 1));

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    frames_d = frames_q;
    won_d    = won_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_q) begin
          state_d  = PLAY;
          score_d  = '0;
          lives_d  = 2'(LIVES);
          frames_d = 12'(TIMEOUT_FRAMES);
          won_d    = 1'b0;
        end
      end
      PLAY: begin
        if (win) begin
          score_d = SW'(MAX_SCORE);
          won_d   = 1'b1;
          state_d = OVER;
        end else begin
          if (hit) begin
            score_d = score_q + SW'(1);
          end
          if (miss && lives_q != 2'd0) begin
            lives_d = lives_q - 2'd1;
          end
          if (screenEnd && frames_q != 12'd0) begin
            frames_d = frames_q - 12'd1;
          end
          if ((miss && lives_q <= 2'd1) ||
              (screenEnd && frames_q <= 12'd1)) begin
            won_d   = 1'b0;
            state_d = OVER;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ingame_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ingame_q <= 1'b0;
      score_q  <= '0;
      lives_q  <= 2'd0;
      frames_q <= 12'd0;
      won_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ingame_q <= ingame_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      frames_q <= frames_d;
      won_q    <= won_d;
    end
  end

  assign ingame      = ingame_q;
  assign score       = {{(32 - SW){1'b0}}, score_q};
  assign lives_left  = lives_q;
  assign frames_left = frames_q;
  assign game_won    = won_q;

endmodule
